// File: rtl/debug_pkg.sv
// Shared command bytes, frame header and FSM state encoding for the debug step controller.
// No logic of its own; zero latency.
// No flow control here; consumers own their handshakes.
package debug_pkg;

    localparam logic [7:0] CMD_RUN   = 8'h63;  // 'c'
    localparam logic [7:0] CMD_HALT  = 8'h68;  // 'h'
    localparam logic [7:0] CMD_STEP  = 8'h73;  // 's'
    localparam logic [7:0] CMD_NSTEP = 8'h6E;  // 'n'
    localparam logic [7:0] CMD_DUMP  = 8'h64;  // 'd'
    localparam logic [7:0] HDR_BYTE  = 8'hA5;

    localparam int CNT_W = 32;

    // The numeric values are visible on the LEDs, so they are pinned explicitly.
    typedef enum logic [2:0] {
        ST_HALT   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_ARG_HI = 3'd3,
        ST_ARG_LO = 3'd4,
        ST_DUMP   = 3'd5
    } state_t;

    // Header + 4 cycle-count bytes + all probe bytes.
    function automatic int frame_len(input int num_words, input int word_w);
        return 5 + num_words * (word_w / 8);
    endfunction

endpackage

// File: rtl/debug_dump_serializer.sv
// Streams one snapshot frame (header, cycle count MSB first, probe words MSB byte first) byte by byte.
// First byte valid the cycle after i_start; one byte per cycle when the transmitter is always ready.
// Byte and valid hold while the transmitter stalls; o_done pulses on acceptance of the final byte.
module debug_dump_serializer
    import debug_pkg::*;
#(
    parameter int NUM_WORDS = 40,
    parameter int WORD_W    = 32
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    input  logic [CNT_W-1:0]              i_cnt,
    input  logic [NUM_WORDS*WORD_W-1:0]   i_probe,
    input  logic                          i_tx_ready,
    output logic [7:0]                    o_tx_data,
    output logic                          o_tx_valid,
    output logic                          o_done
);

    localparam int BPW    = WORD_W / 8;
    localparam int NBYTES = frame_len(NUM_WORDS, WORD_W);
    localparam int IDX_W  = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    logic             r_vld;
    logic [IDX_W-1:0] r_idx;
    logic             w_accept;
    logic             w_last;
    logic [7:0]       w_byte;
    logic [31:0]      w_prel;
    logic [31:0]      w_poff;

    assign w_accept = r_vld && i_tx_ready;
    assign w_last   = (r_idx == LAST_IDX);

    // Map the flat frame index onto header, count byte or probe byte (probes are stable while dumping).
    always_comb begin
        w_byte = 8'h00;
        w_prel = 32'd0;
        w_poff = 32'd0;
        if (r_idx == '0) begin
            w_byte = HDR_BYTE;
        end else if (r_idx <= IDX_W'(4)) begin
            case (r_idx)
                IDX_W'(1): w_byte = i_cnt[31:24];
                IDX_W'(2): w_byte = i_cnt[23:16];
                IDX_W'(3): w_byte = i_cnt[15:8];
                default:   w_byte = i_cnt[7:0];
            endcase
        end else begin
            // Byte offset into the flat probe bus: word base plus reversed position inside the word.
            w_prel = 32'(r_idx) - 32'd5;
            w_poff = (w_prel / 32'(BPW)) * 32'(BPW) + (32'(BPW) - 32'd1 - (w_prel % 32'(BPW)));
            w_byte = 8'(i_probe >> (w_poff * 32'd8));
        end
    end

    // Frame position and valid: load on start, advance on each accepted byte, drop after the last.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld <= 1'b0;
            r_idx <= '0;
        end else if (i_start) begin
            r_vld <= 1'b1;
            r_idx <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_vld <= 1'b0;
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    assign o_tx_valid = r_vld;
    assign o_tx_data  = r_vld ? w_byte : 8'h00;
    assign o_done     = w_accept && w_last;

endmodule

// File: rtl/debug_step_controller.sv
// Decodes UART command bytes into free-run / single-step / N-step pipeline enables and dumps snapshots.
// ena_pip follows a command strobe by one cycle; a step's frame header appears one cycle after its last enabled cycle.
// rx has no backpressure (bytes outside HALT/RUN/ARG states are dropped); tx stalls on tx_ready low.
module debug_step_controller
    import debug_pkg::*;
#(
    parameter int NUM_WORDS = 40,
    parameter int WORD_W    = 32,
    parameter int STEP_W    = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [7:0]                    i_rx_data,
    input  logic                          i_rx_valid,
    output logic [7:0]                    o_tx_data,
    output logic                          o_tx_valid,
    input  logic                          i_tx_ready,
    input  logic [NUM_WORDS*WORD_W-1:0]   i_probe,
    output logic                          o_ena_pip,
    output logic [7:0]                    o_led
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [STEP_W-1:0]   r_remaining;
    logic [STEP_W-1:0]   w_remaining_nxt;
    logic [7:0]          r_arg_hi;
    logic [7:0]          w_arg_hi_nxt;
    logic                r_ena_pip;
    logic                w_ena_nxt;
    logic [CNT_W-1:0]    r_cycle_cnt;
    logic                w_dump_start;
    logic                w_dump_done;

    // Command decode, step countdown and dump sequencing.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_arg_hi_nxt    = r_arg_hi;
        w_dump_start    = 1'b0;
        case (r_state)
            ST_HALT: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        CMD_RUN:   w_state_nxt = ST_RUN;
                        CMD_STEP: begin
                            w_state_nxt     = ST_STEP;
                            w_remaining_nxt = STEP_W'(1);
                        end
                        CMD_NSTEP: w_state_nxt = ST_ARG_HI;
                        CMD_DUMP: begin
                            w_state_nxt  = ST_DUMP;
                            w_dump_start = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        CMD_HALT: w_state_nxt = ST_HALT;
                        CMD_DUMP: begin
                            w_state_nxt  = ST_DUMP;
                            w_dump_start = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_ARG_HI: begin
                if (i_rx_valid) begin
                    w_arg_hi_nxt = i_rx_data;
                    w_state_nxt  = ST_ARG_LO;
                end
            end
            ST_ARG_LO: begin
                if (i_rx_valid) begin
                    w_remaining_nxt = STEP_W'({r_arg_hi, i_rx_data});
                    w_state_nxt     = ST_STEP;
                end
            end
            ST_STEP: begin
                if (r_remaining != '0) begin
                    w_remaining_nxt = r_remaining - STEP_W'(1);
                end
                // Leaving on the last enabled cycle puts the header right after it; N=0 leaves with none.
                if (r_remaining <= STEP_W'(1)) begin
                    w_state_nxt  = ST_DUMP;
                    w_dump_start = 1'b1;
                end
            end
            ST_DUMP: begin
                if (w_dump_done) begin
                    w_state_nxt = ST_HALT;
                end
            end
            default: w_state_nxt = ST_HALT;
        endcase
        // Enable is registered from the next state so it lines up exactly with the state it belongs to.
        w_ena_nxt = (w_state_nxt == ST_RUN) ||
                    ((w_state_nxt == ST_STEP) && (w_remaining_nxt != '0));
    end

    // FSM, step count, argument and enable registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_HALT;
            r_remaining <= '0;
            r_arg_hi    <= 8'h00;
            r_ena_pip   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_arg_hi    <= w_arg_hi_nxt;
            r_ena_pip   <= w_ena_nxt;
        end
    end

    // Count every cycle the pipeline is enabled; wraps naturally at 32 bits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cycle_cnt <= '0;
        end else if (r_ena_pip) begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
        end
    end

    debug_dump_serializer #(
        .NUM_WORDS (NUM_WORDS),
        .WORD_W    (WORD_W)
    ) u_dump (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (w_dump_start),
        .i_cnt      (r_cycle_cnt),
        .i_probe    (i_probe),
        .i_tx_ready (i_tx_ready),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .o_done     (w_dump_done)
    );

    assign o_ena_pip = r_ena_pip;
    assign o_led     = {r_cycle_cnt[4:0], r_state};

endmodule

// File: tb/tb_debug_step_controller.sv
// Self-checking bench for debug_step_controller with two 32-bit probe words.
// Table vectors, hand timing sequences and randomized operations against a frame/count model.
// tx_ready is randomly throttled for some operations to exercise the hold behaviour.
module tb_debug_step_controller;

    localparam int NW = 2;
    localparam int WW = 32;
    localparam int NB = 5 + NW * WW / 8;

    localparam int K_STEP     = 0;
    localparam int K_NSTEP    = 1;
    localparam int K_DUMP     = 2;
    localparam int K_RUN_DUMP = 3;
    localparam int K_RUN_HALT = 4;
    localparam int K_JUNK     = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [NW*WW-1:0]  probe;
    logic              ena;
    logic [7:0]        led;

    debug_step_controller #(.NUM_WORDS(NW), .WORD_W(WW), .STEP_W(16)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready),
        .i_probe    (probe),
        .o_ena_pip  (ena),
        .o_led      (led)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          rdy_pct = 100;
    int          strobe_cyc = 0;
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    int          ena_cnt, ena_first, ena_last, hold_err, ovl_err;
    bit          prev_stall;
    logic [7:0]  prev_dat;
    logic [31:0] model_cnt;

    typedef struct {
        int kind;
        int arg;
        int pct;
        int exp_ena;
        bit exp_frame;
    } vec_t;
    vec_t vt[9];

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            tx_ready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(99) < rdy_pct);
        end
    end

    // Observer: enabled cycles, accepted bytes, stall-hold and enable/valid overlap violations.
    initial begin
        prev_stall = 1'b0;
        prev_dat   = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (ena) begin
                    if (ena_cnt == 0) ena_first = cyc;
                    ena_last = cyc;
                    ena_cnt  = ena_cnt + 1;
                end
                if (prev_stall && (!tx_valid || tx_data !== prev_dat)) hold_err = hold_err + 1;
                if (ena && tx_valid) ovl_err = ovl_err + 1;
                if (tx_valid && tx_ready) got_q.push_back(tx_data);
                prev_stall = tx_valid && !tx_ready;
                prev_dat   = tx_data;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        ena_cnt   = 0;
        ena_first = 0;
        ena_last  = 0;
        hold_err  = 0;
        ovl_err   = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #2;
        rx_data    = b;
        rx_valid   = 1'b1;
        strobe_cyc = cyc;
        @(posedge clk);
        #2;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    // Expected frame: header, count MSB first, word0 then word1 each MSB byte first.
    task automatic build_exp(input logic [31:0] c);
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(c[31:24]);
        exp_q.push_back(c[23:16]);
        exp_q.push_back(c[15:8]);
        exp_q.push_back(c[7:0]);
        exp_q.push_back(8'hDE); exp_q.push_back(8'hAD); exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    endtask

    task automatic check_frame(input string name);
        int bad;
        bad = -1;
        n_tests = n_tests + 1;
        if (got_q.size() != exp_q.size()) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: frame length %0d, expected %0d", name, got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++)
                if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
            if (bad >= 0) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: byte %0d got %0h, expected %0h", name, bad, got_q[bad], exp_q[bad]);
            end
        end
    endtask

    task automatic wait_frame_done(input string name, input int budget);
        int k;
        k = 0;
        while ((got_q.size() < NB || tx_valid) && k < budget) begin
            @(posedge clk);
            #1;
            k = k + 1;
        end
        if (k >= budget) begin
            n_tests = n_tests + 1;
            n_fail  = n_fail + 1;
            $display("FAIL %s_timeout: %0d bytes after %0d cycles, expected %0d", name, got_q.size(), k, NB);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // One operation from HALT back to HALT; exp_ena < 0 means "cycles between run and stop strobes".
    task automatic run_op(input string name, input int kind, input int arg, input int pct,
                          input int exp_ena_in, input bit exp_frame, input bit junk);
        int t0;
        int exp_ena;
        rdy_pct = pct;
        clear_mon();
        t0 = 0;
        case (kind)
            K_STEP: begin
                send_byte(8'h73);
                t0 = strobe_cyc;
                if (junk) send_byte(8'h63);
            end
            K_NSTEP: begin
                send_byte(8'h6E);
                send_byte(arg[15:8]);
                send_byte(arg[7:0]);
                t0 = strobe_cyc;
                if (junk) send_byte(8'h63);
            end
            K_DUMP: begin
                send_byte(8'h64);
                t0 = strobe_cyc;
                if (junk) send_byte(8'h73);
            end
            K_RUN_DUMP, K_RUN_HALT: begin
                send_byte(8'h63);
                t0 = strobe_cyc;
                if (junk) begin
                    repeat (arg / 3) @(posedge clk);
                    send_byte(($urandom_range(1) == 0) ? 8'h73 : 8'h6E);
                    repeat (arg / 3) @(posedge clk);
                end else begin
                    repeat (arg - 2) @(posedge clk);
                end
                send_byte((kind == K_RUN_DUMP) ? 8'h64 : 8'h68);
            end
            default: send_byte(arg[7:0]);
        endcase
        exp_ena   = (exp_ena_in < 0) ? (strobe_cyc - t0) : exp_ena_in;
        model_cnt = model_cnt + 32'(exp_ena);
        if (exp_frame) begin
            wait_frame_done(name, exp_ena + NB * 40 + 100);
            build_exp(model_cnt);
            check_frame({name, "_frame"});
        end else begin
            repeat (12) @(posedge clk);
            #1;
            check({name, "_noframe"}, 32'(got_q.size()), 32'd0);
        end
        check({name, "_ena_cycles"}, 32'(ena_cnt), 32'(exp_ena));
        if (ena_cnt > 0) begin
            check({name, "_ena_contig"}, 32'(ena_last - ena_first + 1), 32'(ena_cnt));
            check({name, "_ena_start"}, 32'(ena_first), 32'(t0 + 1));
        end
        check({name, "_hold"}, 32'(hold_err + ovl_err), 32'd0);
        check({name, "_led"}, 32'(led), 32'({model_cnt[4:0], 3'b000}));
    endtask

    initial begin
        int t_c;
        int k;
        int kind;
        int arg;
        bit junk;
        bit frame;
        int pct;

        vt[0] = '{K_STEP,     0,      100, 1,   1'b1};
        vt[1] = '{K_NSTEP,    5,      100, 5,   1'b1};
        vt[2] = '{K_NSTEP,    0,      100, 0,   1'b1};
        vt[3] = '{K_RUN_DUMP, 100,    100, 100, 1'b1};
        vt[4] = '{K_RUN_HALT, 50,     100, 50,  1'b0};
        vt[5] = '{K_JUNK,     8'h68,  100, 0,   1'b0};
        vt[6] = '{K_JUNK,     8'h41,  100, 0,   1'b0};
        vt[7] = '{K_DUMP,     0,      30,  0,   1'b1};
        vt[8] = '{K_NSTEP,    16'h0102, 30, 258, 1'b1};

        probe     = {32'h11223344, 32'hDEADBEEF};
        rst_n     = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        model_cnt = 32'd0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ena", 32'(ena), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_led", 32'(led), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors; the first one is the single step from reset (count 1, led 0x08).
        for (int i = 0; i < 9; i++)
            run_op($sformatf("vec%0d", i), vt[i].kind, vt[i].arg, vt[i].pct,
                   vt[i].exp_ena, vt[i].exp_frame, 1'b0);

        // 's' timing: enable only in t+1, header at t+2.
        rdy_pct = 100;
        clear_mon();
        send_byte(8'h73);
        @(negedge clk);
        check("s_ena_t1", 32'(ena), 32'd1);
        check("s_txv_t1", 32'(tx_valid), 32'd0);
        @(negedge clk);
        check("s_ena_t2", 32'(ena), 32'd0);
        check("s_txv_t2", 32'(tx_valid), 32'd1);
        check("s_hdr_t2", 32'(tx_data), 32'hA5);
        model_cnt = model_cnt + 32'd1;
        wait_frame_done("s_timing", 200);
        build_exp(model_cnt);
        check_frame("s_timing_frame");

        // 'c' then 'd' in RUN: enable drops and header appears in the same cycle.
        clear_mon();
        send_byte(8'h63);
        t_c = strobe_cyc;
        @(negedge clk);
        check("c_ena_t1", 32'(ena), 32'd1);
        repeat (20) @(posedge clk);
        send_byte(8'h64);
        @(negedge clk);
        check("d_ena_t1", 32'(ena), 32'd0);
        check("d_txv_t1", 32'(tx_valid), 32'd1);
        check("d_hdr_t1", 32'(tx_data), 32'hA5);
        model_cnt = model_cnt + 32'(strobe_cyc - t_c);
        wait_frame_done("cd_timing", 200);
        build_exp(model_cnt);
        check_frame("cd_timing_frame");

        // 'c' then 'h': enable drops the next cycle, nothing transmitted.
        clear_mon();
        send_byte(8'h63);
        t_c = strobe_cyc;
        send_byte(8'h68);
        @(negedge clk);
        check("h_ena_t1", 32'(ena), 32'd0);
        model_cnt = model_cnt + 32'(strobe_cyc - t_c);
        repeat (6) @(negedge clk);
        check("h_no_tx", 32'(got_q.size()) + 32'(tx_valid), 32'd0);
        check("h_ena_cycles", 32'(ena_cnt), 32'(strobe_cyc - t_c));

        // Counter wrap: preset near the top while halted, then step 3.
        @(negedge clk);
        force dut.r_cycle_cnt = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.r_cycle_cnt;
        model_cnt = 32'hFFFF_FFFE;
        run_op("wrap", K_NSTEP, 3, 100, 3, 1'b1, 1'b0);

        // Randomized operations against the model.
        for (int it = 0; it < 30; it++) begin
            kind  = int'($urandom_range(5));
            pct   = ($urandom_range(1) == 1) ? 30 : 100;
            junk  = 1'($urandom_range(1));
            arg   = 0;
            frame = (kind == K_STEP) || (kind == K_NSTEP) || (kind == K_DUMP) || (kind == K_RUN_DUMP);
            case (kind)
                K_NSTEP:    arg = ($urandom_range(3) == 0) ? int'($urandom_range(256, 300))
                                                          : int'($urandom_range(12));
                K_RUN_DUMP,
                K_RUN_HALT: arg = int'($urandom_range(10, 60));
                K_JUNK: begin
                    k = int'($urandom_range(3));
                    arg = (k == 0) ? 8'h00 : (k == 1) ? 8'h68 : (k == 2) ? 8'hFF : 8'h43;
                end
                default:    arg = 0;
            endcase
            run_op($sformatf("rnd%0d", it), kind, arg, pct,
                   (kind == K_STEP) ? 1 : (kind == K_NSTEP) ? arg :
                   (kind == K_RUN_DUMP || kind == K_RUN_HALT) ? -1 : 0,
                   frame, junk);
        end

        // Reset in the middle of a frame aborts it at once; afterwards a dump reports count 0.
        rdy_pct = 100;
        clear_mon();
        send_byte(8'h64);
        k = 0;
        while (got_q.size() < 6 && k < 200) begin
            @(posedge clk);
            #1;
            k = k + 1;
        end
        check("mid_reached_byte6", 32'(got_q.size() >= 6), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_txv", 32'(tx_valid), 32'd0);
        check("mid_rst_ena", 32'(ena), 32'd0);
        check("mid_rst_txd", 32'(tx_data), 32'd0);
        check("mid_rst_led", 32'(led), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_cnt = 32'd0;
        run_op("post_rst_dump", K_DUMP, 0, 100, 0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
